// File: rtl/acc_stack.sv
// -----------------------------------------------------------------------------
// acc_stack
// Registered accumulator that loads from one of NSRC source buses. It has a
// DEPTH-entry LIFO so the accumulator can be saved and restored without using
// the register file.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   src_data   packed sources, source i at [i*WIDTH +: WIDTH]
//   src_sel    source select for a load
//   wr_en      load accumulator from selected source
//   push       save accumulator onto the stack
//   pop        restore accumulator from the stack
//   clr_err    clear sticky error flags (a same-cycle new error wins)
//   acc_out    registered accumulator
//   stack_cnt  number of entries currently on the stack
//   full       stack_cnt == DEPTH
//   empty      stack_cnt == 0
//   zero       acc_out == 0
//   err_ovf    sticky: push attempted while full
//   err_unf    sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module acc_stack #(
    parameter int               WIDTH     = 8,
    parameter int               NSRC      = 4,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NSRC*WIDTH-1:0]      src_data,
    input  logic [$clog2(NSRC)-1:0]    src_sel,
    input  logic                       wr_en,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           acc_out,
    output logic [$clog2(DEPTH+1)-1:0] stack_cnt,
    output logic                       full,
    output logic                       empty,
    output logic                       zero,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int SEL_W = $clog2(NSRC);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Source buses unpacked into an array for the load mux.
    logic [WIDTH-1:0] src_arr [NSRC];

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
    end

    // Load mux. A select beyond NSRC-1 (non-power-of-2 NSRC) matches no
    // source, so wr_en is dropped for that cycle.
    logic [WIDTH-1:0] load_val;
    logic             sel_valid;

    always_comb begin
        load_val  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                load_val  = src_arr[i];
                sel_valid = 1'b1;
            end
        end
    end

    // State
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic             full_int;
    logic             empty_int;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] top_val;
    logic             wr_eff;

    assign full_int  = (cnt_reg == CNT_W'(DEPTH));
    assign empty_int = (cnt_reg == '0);
    // Only meaningful when the stack is not empty.
    assign top_idx   = IDX_W'(cnt_reg - CNT_W'(1));
    assign top_val   = stack_mem[top_idx];
    // A load with an out-of-range select behaves as if wr_en were low.
    assign wr_eff    = wr_en & sel_valid;

    always_comb begin
        acc_next  = acc_reg;
        cnt_next  = cnt_reg;
        // Clear first, so an error raised this cycle overrides clr_err.
        ovf_next  = ovf_reg & ~clr_err;
        unf_next  = unf_reg & ~clr_err;
        mem_we    = 1'b0;
        mem_waddr = cnt_reg[IDX_W-1:0];
        mem_wdata = acc_reg;

        unique casez ({push, pop, wr_eff})
            3'b001: acc_next = load_val;
            3'b100, 3'b101: begin
                // Push (save) uses the old accumulator. On 101 the load
                // happens even when the push is refused.
                if (!full_int) begin
                    mem_we   = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    ovf_next = 1'b1;
                end
                if (wr_eff) acc_next = load_val;
            end
            3'b010: begin
                if (!empty_int) begin
                    acc_next = top_val;
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    unf_next = 1'b1;
                end
            end
            3'b011: begin
                // Discard the top and load.
                acc_next = load_val;
                if (!empty_int) cnt_next = cnt_reg - CNT_W'(1);
                else            unf_next = 1'b1;
            end
            3'b11?: begin
                // Swap accumulator with the top entry; wr_en is ignored.
                if (!empty_int) begin
                    acc_next  = top_val;
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                end else begin
                    unf_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= RESET_VAL;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    // The stack storage is not reset. Zeroing cnt_reg is enough to make old
    // entries unreachable.
    always_ff @(posedge clk) begin
        if (mem_we) stack_mem[mem_waddr] <= mem_wdata;
    end

    assign acc_out   = acc_reg;
    assign stack_cnt = cnt_reg;
    assign full      = full_int;
    assign empty     = empty_int;
    assign zero      = (acc_reg == '0);
    assign err_ovf   = ovf_reg;
    assign err_unf   = unf_reg;

endmodule
